// File: rtl/pulse_gen.sv
// Retriggerable pulse generator: HIGH for the requested width, then a guaranteed LOW gap.
// Define PULSE_GEN_BURST_EN to add burst_in and repeat each request's pulse B times.
module pulse_gen #(
  parameter int WIDTH_W = 8,
  parameter int MIN_LOW = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               trig_in,
  input  logic [WIDTH_W-1:0] width_in,
`ifdef PULSE_GEN_BURST_EN
  input  logic [3:0]         burst_in,
`endif
  output logic               pulse_out,
  output logic               busy,
  output logic               done_out,
  output logic               drop_out
);

  // state | meaning
  // IDLE  | no request active, outputs low
  // HIGH  | pulse high, cnt counts remaining high cycles
  // LOW   | mandatory gap, cnt counts remaining low cycles
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  // Counter must hold both the widest pulse and the longest gap.
  localparam int CW = (WIDTH_W > 8) ? WIDTH_W : 8;

  state_t             state, state_nx;
  logic [CW-1:0]      cnt, cnt_nx;
  logic               pend_vld, pend_vld_nx;
  logic [WIDTH_W-1:0] pend_w, pend_w_nx;
  logic [WIDTH_W-1:0] in_w;
  logic               last_low, more;
  logic               pulse_nx, busy_nx, done_nx, drop_nx;

`ifdef PULSE_GEN_BURST_EN
  logic [3:0]         burst_rem, burst_rem_nx;
  logic [3:0]         pend_b, pend_b_nx;
  logic [3:0]         in_b;
  logic [WIDTH_W-1:0] w_lat, w_lat_nx;

  assign in_b = (burst_in == 4'd0) ? 4'd1 : burst_in;
  assign more = (burst_rem != 4'd0);
`else
  assign more = 1'b0;
`endif

  assign in_w     = (width_in == '0) ? WIDTH_W'(1) : width_in;
  assign last_low = (state == LOW) && (cnt == '0);

  function automatic logic [CW-1:0] high_load(input logic [WIDTH_W-1:0] w);
    return CW'(w) - CW'(1);
  endfunction

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    pend_vld_nx = pend_vld;
    pend_w_nx   = pend_w;
    drop_nx     = 1'b0;
`ifdef PULSE_GEN_BURST_EN
    burst_rem_nx = burst_rem;
    pend_b_nx    = pend_b;
    w_lat_nx     = w_lat;
`endif

    case (state)
      IDLE: begin
        if (trig_in) begin
          state_nx = HIGH;
          cnt_nx   = high_load(in_w);
`ifdef PULSE_GEN_BURST_EN
          w_lat_nx     = in_w;
          burst_rem_nx = in_b - 4'd1;
`endif
        end
      end
      HIGH: begin
        if (cnt == '0) begin
          state_nx = LOW;
          cnt_nx   = CW'(MIN_LOW - 1);
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      LOW: begin
        if (cnt != '0) begin
          cnt_nx = cnt - CW'(1);
        end else if (more) begin
          state_nx = HIGH;
`ifdef PULSE_GEN_BURST_EN
          cnt_nx       = high_load(w_lat);
          burst_rem_nx = burst_rem - 4'd1;
`endif
        end else if (pend_vld) begin
          state_nx    = HIGH;
          cnt_nx      = high_load(pend_w);
          pend_vld_nx = 1'b0;
`ifdef PULSE_GEN_BURST_EN
          w_lat_nx     = pend_w;
          burst_rem_nx = pend_b - 4'd1;
`endif
        end else if (trig_in) begin
          // Request arriving in the final gap cycle with nothing queued starts
          // straight away, exactly as if it had passed through the pending slot.
          state_nx = HIGH;
          cnt_nx   = high_load(in_w);
`ifdef PULSE_GEN_BURST_EN
          w_lat_nx     = in_w;
          burst_rem_nx = in_b - 4'd1;
`endif
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (trig_in && (state != IDLE) && !(last_low && !more && !pend_vld)) begin
      if (pend_vld) begin
        drop_nx = 1'b1;
      end else begin
        pend_vld_nx = 1'b1;
        pend_w_nx   = in_w;
`ifdef PULSE_GEN_BURST_EN
        pend_b_nx   = in_b;
`endif
      end
    end

    pulse_nx = (state_nx == HIGH);
    busy_nx  = (state_nx != IDLE);
`ifdef PULSE_GEN_BURST_EN
    done_nx  = (state_nx == LOW) && (cnt_nx == '0) && (burst_rem_nx == 4'd0);
`else
    done_nx  = (state_nx == LOW) && (cnt_nx == '0);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      pend_vld  <= 1'b0;
      pend_w    <= '0;
      pulse_out <= 1'b0;
      busy      <= 1'b0;
      done_out  <= 1'b0;
      drop_out  <= 1'b0;
`ifdef PULSE_GEN_BURST_EN
      burst_rem <= '0;
      pend_b    <= '0;
      w_lat     <= '0;
`endif
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      pend_vld  <= pend_vld_nx;
      pend_w    <= pend_w_nx;
      pulse_out <= pulse_nx;
      busy      <= busy_nx;
      done_out  <= done_nx;
      drop_out  <= drop_nx;
`ifdef PULSE_GEN_BURST_EN
      burst_rem <= burst_rem_nx;
      pend_b    <= pend_b_nx;
      w_lat     <= w_lat_nx;
`endif
    end
  end

endmodule

// File: tb/tb_pulse_gen.sv
// Directed bench for pulse_gen (MIN_LOW=2): per-cycle expected masks written by hand.
// Also exercises burst mode when built with PULSE_GEN_BURST_EN.
module tb_pulse_gen;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       trig_in = 1'b0;
  logic [7:0] width_in = 8'd0;
`ifdef PULSE_GEN_BURST_EN
  logic [3:0] burst_in = 4'd0;
`endif
  logic       pulse_out, busy, done_out, drop_out;

  int total = 0;
  int bad = 0;
  logic [7:0] wsched [32];
  logic [3:0] bsched [32];

  pulse_gen #(.WIDTH_W(8), .MIN_LOW(2)) dut (
    .clk(clk), .rst_n(rst_n), .trig_in(trig_in), .width_in(width_in),
`ifdef PULSE_GEN_BURST_EN
    .burst_in(burst_in),
`endif
    .pulse_out(pulse_out), .busy(busy), .done_out(done_out), .drop_out(drop_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rng(input int lo, input int hi);
    logic [31:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic chk_all(input string tag, input int c, input logic p, input logic b,
                         input logic d, input logic dr);
    chk($sformatf("%s c%0d pulse", tag, c), pulse_out, p);
    chk($sformatf("%s c%0d busy", tag, c), busy, b);
    chk($sformatf("%s c%0d done", tag, c), done_out, d);
    chk($sformatf("%s c%0d drop", tag, c), drop_out, dr);
  endtask

  task automatic clear_sched();
    for (int i = 0; i < 32; i++) begin
      wsched[i] = 8'd0;
      bsched[i] = 4'd0;
    end
  endtask

  // Caller is at a post-edge point with the DUT idle; that cycle is numbered 9.
  task automatic run(input string tag, input logic [31:0] tm, input logic [31:0] pm,
                     input logic [31:0] bm, input logic [31:0] dm, input logic [31:0] drm,
                     input int last);
    for (int c = 9; c <= last; c++) begin
      trig_in  = tm[c];
      width_in = wsched[c];
`ifdef PULSE_GEN_BURST_EN
      burst_in = bsched[c];
`endif
      chk_all(tag, c, pm[c], bm[c], dm[c], drm[c]);
      tick();
    end
    trig_in = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int n;
    clear_sched();

    // Reset held for 3 cycles while trig_in toggles.
    #2;
    for (int c = 0; c < 3; c++) begin
      trig_in  = c[0];
      width_in = 8'd3;
      tick();
      chk_all("rst_hold", c, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    trig_in = 1'b0;
    rst_n = 1'b1;
    tick();
    tick();

    wsched[10] = 8'd3;
    run("w3", rng(10, 10), rng(11, 13), rng(11, 15), rng(15, 15), '0, 17);

    clear_sched();
    wsched[10] = 8'd0;
    run("w0", rng(10, 10), rng(11, 11), rng(11, 13), rng(13, 13), '0, 15);

    clear_sched();
    wsched[10] = 8'd2; wsched[12] = 8'd4; wsched[13] = 8'd7;
    run("pend_drop", rng(10, 10) | rng(12, 13), rng(11, 12) | rng(15, 18), rng(11, 20),
        rng(14, 14) | rng(20, 20), rng(14, 14), 22);

    clear_sched();
    wsched[10] = 8'd1; wsched[13] = 8'd2;
    run("last_low_trig", rng(10, 10) | rng(13, 13), rng(11, 11) | rng(14, 15), rng(11, 17),
        rng(13, 13) | rng(17, 17), '0, 19);

    // Maximum width: 255 high cycles, no wrap.
    trig_in = 1'b1; width_in = 8'd255;
    tick();
    trig_in = 1'b0;
    n = 0;
    while (pulse_out === 1'b1 && n < 300) begin
      n++;
      tick();
    end
    chk_int("w255 high_cycles", n, 255);
    chk("w255 gap1 busy", busy, 1'b1);
    chk("w255 gap1 done", done_out, 1'b0);
    tick();
    chk("w255 gap2 done", done_out, 1'b1);
    tick();
    chk("w255 idle busy", busy, 1'b0);
    tick();

    // Reset mid-pulse with a request pending.
    trig_in = 1'b1; width_in = 8'd5;
    tick();
    chk("rst_mid c11 pulse", pulse_out, 1'b1);
    width_in = 8'd3;
    tick();
    trig_in = 1'b0;
    chk("rst_mid c12 pulse", pulse_out, 1'b1);
    tick();
    chk("rst_mid c13 pulse", pulse_out, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid async pulse", pulse_out, 1'b0);
    chk("rst_mid async busy", busy, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk_all("rst_after", c, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    trig_in = 1'b1; width_in = 8'd1;
    tick();
    trig_in = 1'b0;
    chk_all("rst_w1 c1", 1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("rst_w1 c2", 2, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("rst_w1 c3", 3, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    chk_all("rst_w1 c4", 4, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

`ifdef PULSE_GEN_BURST_EN
    clear_sched();
    wsched[10] = 8'd2; bsched[10] = 4'd3;
    run("burst3", rng(10, 10), rng(11, 12) | rng(15, 16) | rng(19, 20), rng(11, 22),
        rng(22, 22), '0, 24);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_gen.md
PULSE_GEN -- requirements
Module: pulse_gen

Interface
REQ-001 Parameter: WIDTH_W, default 8, bit width of the pulse-width request.
REQ-002 Parameter: MIN_LOW, default 2, guaranteed low cycles after every pulse; legal range 1..255.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: trig_in  input  1  request strobe; each cycle it is sampled high is one request.
REQ-006 Port: width_in  input  WIDTH_W  high time in cycles; sampled with trig_in; 0 is treated as 1.
REQ-007 Port: burst_in  input  4  pulses per request; present only when PULSE_GEN_BURST_EN is defined; 0 is treated as 1.
REQ-008 Port: pulse_out  output  1  registered generated pulse.
REQ-009 Port: busy  output  1  registered; high while a pulse or its low gap is in progress.
REQ-010 Port: done_out  output  1  registered; one-cycle strobe at the end of a request's final gap.
REQ-011 Port: drop_out  output  1  registered; one-cycle strobe when a request is discarded.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, HIGH and LOW.
REQ-013 IDLE SHALL behave as follows: pulse_out=0, busy=0; a trig_in high in cycle n SHALL move the FSM to HIGH and latch the width (0 becomes 1).
REQ-014 HIGH SHALL behave as follows: pulse_out=1 for exactly W cycles (n+1..n+W), then the FSM SHALL move to LOW.
REQ-015 LOW SHALL behave as follows: pulse_out=0 for exactly MIN_LOW cycles; at the end, the FSM SHALL go to HIGH if a pulse or request remains, otherwise to IDLE.
REQ-016 The latency from trig_in to pulse_out rising SHALL be exactly one cycle when the FSM is in IDLE.
REQ-017 busy SHALL be 1 in every HIGH or LOW cycle and 0 in IDLE.
REQ-018 done_out SHALL be 1 during the last LOW cycle of the final pulse of a request, and 0 otherwise.
REQ-019 A trig_in while busy=1 with the pending slot empty SHALL be stored in a one-deep pending register, holding the width and, when configured, the burst count.
REQ-020 A pending request SHALL start HIGH in the cycle after the last LOW cycle, and the pending slot SHALL clear on entry.
REQ-021 A trig_in while busy=1 with the pending slot full SHALL be discarded; drop_out SHALL be 1 in the following cycle and state SHALL be unaffected.
REQ-022 A trig_in during the last LOW cycle SHALL be treated as busy, going to pending or being dropped under the rules above.
REQ-023 The width counter SHALL be WIDTH_W bits wide; a width of 2^WIDTH_W-1 SHALL produce exactly that many high cycles with no wrap.
REQ-024 No output SHALL depend combinationally on any input.

Reset
REQ-025 rst_n low SHALL immediately force the FSM to IDLE and set pulse_out, busy, done_out and drop_out to 0, regardless of the clock.
REQ-026 rst_n low SHALL clear the pending slot and all counters.
REQ-027 A reset asserted mid-pulse SHALL truncate the pulse, and no done_out SHALL be issued for the interrupted request.
REQ-028 After rst_n deasserts, the first trig_in SHALL behave exactly as in REQ-013.

Configuration
REQ-029 When PULSE_GEN_BURST_EN is defined, the burst_in port SHALL exist, and each request SHALL produce B repetitions of HIGH(W) followed by LOW(MIN_LOW), with done_out only after the B-th LOW.
REQ-030 When PULSE_GEN_BURST_EN is undefined, the burst_in port and burst counter SHALL be absent, and each request SHALL produce exactly one pulse.

Verification (MIN_LOW=2)
REQ-031 The bench SHALL cover: hold rst_n=0 for 3 cycles, toggling trig_in -> all outputs 0 throughout.
REQ-032 The bench SHALL cover: trig_in in cycle 10 with width_in=3 -> pulse_out=1 in cycles 11-13; busy=1 in cycles 11-15; done_out=1 in cycle 15 only.
REQ-033 The bench SHALL cover: trig_in in cycle 10 with width_in=0 -> pulse_out=1 in cycle 11 only; done_out=1 in cycle 13.
REQ-034 The bench SHALL cover: trig_in in cycle 10 with w=2, in cycle 12 with w=4, and in cycle 13 -> pulse_out=1 in cycles 11-12 and 15-18; drop_out=1 in cycle 14; done_out=1 in cycles 14 and 20.
REQ-035 The bench SHALL cover: trig_in in cycle 10 with w=5, pending trig_in in cycle 11, and rst_n=0 mid-cycle 13 -> pulse_out falls without waiting for a clock edge; no done_out; after release, trig_in with w=1 gives pulse_out=1 for one cycle.
REQ-036 The bench SHALL cover, with PULSE_GEN_BURST_EN defined: trig_in in cycle 10 with w=2, burst_in=3 -> pulse_out=1 in cycles 11-12, 15-16 and 19-20; done_out=1 in cycle 22 only.
